// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 FIFO path: mode codes, axis tags, sequencer states.
// Set-size helper honours the optional temperature entry (ADXL362_FIFO_TEMP_EN).
package adxl362_pkg;

  localparam logic [1:0] FIFO_DISABLED = 2'b00;
  localparam logic [1:0] FIFO_OLDEST   = 2'b01;
  localparam logic [1:0] FIFO_STREAM   = 2'b10;

  localparam logic [1:0] TAG_X = 2'b00;
  localparam logic [1:0] TAG_Y = 2'b01;
  localparam logic [1:0] TAG_Z = 2'b10;
  localparam logic [1:0] TAG_T = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    DROP  = 2'b10,
    WRITE = 2'b11
  } fifo_state_e;

  // Bytes per sample set: three 16-bit entries, plus one for temperature.
  function automatic logic [3:0] set_size(input logic temp_en);
    return temp_en ? 4'd8 : 4'd6;
  endfunction

endpackage

// File: rtl/adxl362_fifo_ctrl_if.sv
// Storage-side bus between the FIFO sequencer (master) and the byte storage (slave).
// Each strobe is one complete transfer; storage has no backpressure, so every strobe is taken.
interface adxl362_fifo_ctrl_if;
  logic       fifo_wr;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd;
  logic       fifo_flush;

  modport master (output fifo_wr, fifo_wr_data, fifo_rd, fifo_flush);
  modport slave  (input  fifo_wr, fifo_wr_data, fifo_rd, fifo_flush);
endinterface

// File: rtl/adxl362_entry_fmt.sv
// Builds one byte of a tagged 16-bit FIFO entry: {tag, 2x sign, data[11:0]}.
// Shared with the SPI register read path.
module adxl362_entry_fmt
  import adxl362_pkg::*;
(
  input  logic [1:0]  axis,
  input  logic [11:0] data,
  input  logic        hi,
  output logic [7:0]  data_byte
);

  logic [1:0]  tag;
  logic [15:0] entry;

  always_comb begin
    tag = TAG_X;
    case (axis)
      2'd0:    tag = TAG_X;
      2'd1:    tag = TAG_Y;
      2'd2:    tag = TAG_Z;
      default: tag = TAG_T;
    endcase
    entry     = {tag, {2{data[11]}}, data};
    data_byte = hi ? entry[15:8] : entry[7:0];
  end

endmodule

// File: rtl/adxl362_fifo_ctrl.sv
// ADXL362 FIFO write/drop/read sequencer with authoritative byte count.
// Define ADXL362_FIFO_TEMP_EN to enable the optional temperature entry.
module adxl362_fifo_ctrl
  import adxl362_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int CNT_W       = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [11:0]         sample_x,
  input  logic [11:0]         sample_y,
  input  logic [11:0]         sample_z,
  input  logic [11:0]         sample_t,
  input  logic [1:0]          fifo_mode,
  input  logic                fifo_temp,
  input  logic [8:0]          fifo_samples,
  input  logic                rd_req,
  input  logic                ovr_clr,
  adxl362_fifo_ctrl_if.master store,
  output logic [CNT_W-1:0]    fifo_bytes,
  output logic                watermark,
  output logic                overrun,
  output logic                busy,
  output fifo_state_e         dbg_state
);

  fifo_state_e    state, state_nxt;
  logic [11:0]    lat_x, lat_y, lat_z, axis_data;
`ifdef ADXL362_FIFO_TEMP_EN
  logic [11:0]    lat_t;
`else
  logic           unused_temp;
`endif
  logic [3:0]     set_bytes, drop_cnt, need, drop_init;
  logic [2:0]     byte_idx;
  logic [1:0]     mode_q;
  logic [7:0]     fmt_byte;
  logic [CNT_W:0] free;
  logic           flush, accept, fits, stream, last_byte;
  logic           pop, drop_rd, wr, rd, ovr_set;

`ifndef ADXL362_FIFO_TEMP_EN
  assign unused_temp = fifo_temp ^ (^sample_t);
`endif

  assign flush     = !reset && fifo_mode == FIFO_DISABLED && mode_q != FIFO_DISABLED;
  assign accept    = sample_valid && state == IDLE && fifo_mode != FIFO_DISABLED;
  assign stream    = fifo_mode[1];  // 10 and 11 both stream
  assign free      = (CNT_W+1)'(DEPTH_BYTES) - {1'b0, fifo_bytes};
  assign fits      = free >= (CNT_W+1)'(set_bytes);
  // Only consulted when free < S, so free fits in four bits; drops stay entry-aligned.
  assign need      = set_bytes - free[3:0];
  assign drop_init = need + {3'b000, need[0]};
  assign last_byte = {1'b0, byte_idx} == set_bytes - 4'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = CHECK;
        CHECK:   if (fits) state_nxt = WRITE;
                 else if (stream) state_nxt = DROP;
                 else state_nxt = IDLE;
        DROP:    if (drop_cnt == 4'd1) state_nxt = WRITE;
        WRITE:   if (wr && last_byte) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A granted pop wins the single storage slot; writer and dropper hold position.
  always_comb begin
    pop     = !reset && rd_req && fifo_bytes != '0 && state != DROP && !flush;
    drop_rd = !reset && state == DROP && !flush;
    wr      = !reset && state == WRITE && !pop && !flush;
    busy    = state != IDLE;
  end

  assign rd      = pop | drop_rd;
  assign ovr_set = !reset && ((sample_valid && state != IDLE) ||
                              (state == CHECK && !fits && !stream && !flush) || drop_rd);

  always_comb begin
    axis_data = 12'h000;
    case (byte_idx[2:1])
      2'd0:    axis_data = lat_x;
      2'd1:    axis_data = lat_y;
      2'd2:    axis_data = lat_z;
`ifdef ADXL362_FIFO_TEMP_EN
      default: axis_data = lat_t;
`else
      default: axis_data = 12'h000;
`endif
    endcase
  end

  adxl362_entry_fmt u_fmt (
    .axis      (byte_idx[2:1]),
    .data      (axis_data),
    .hi        (byte_idx[0]),
    .data_byte (fmt_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= FIFO_DISABLED;
      fifo_bytes <= '0;
      overrun    <= 1'b0;
      byte_idx   <= '0;
      drop_cnt   <= '0;
      set_bytes  <= set_size(1'b0);
      lat_x      <= '0;
      lat_y      <= '0;
      lat_z      <= '0;
`ifdef ADXL362_FIFO_TEMP_EN
      lat_t      <= '0;
`endif
    end else begin
      mode_q <= fifo_mode;
      if (accept) begin
        lat_x    <= sample_x;
        lat_y    <= sample_y;
        lat_z    <= sample_z;
        byte_idx <= '0;
`ifdef ADXL362_FIFO_TEMP_EN
        lat_t     <= sample_t;
        set_bytes <= set_size(fifo_temp);
`else
        set_bytes <= set_size(1'b0);
`endif
      end else if (wr) begin
        byte_idx <= byte_idx + 3'd1;
      end
      if (state == CHECK)  drop_cnt <= drop_init;
      else if (drop_rd)    drop_cnt <= drop_cnt - 4'd1;
      if (flush)           fifo_bytes <= '0;
      else if (wr)         fifo_bytes <= fifo_bytes + CNT_W'(1);
      else if (rd)         fifo_bytes <= fifo_bytes - CNT_W'(1);
      if (ovr_set)         overrun <= 1'b1;
      else if (ovr_clr)    overrun <= 1'b0;
    end
  end

  assign watermark = (fifo_samples != 9'd0) &&
                     ({1'b0, fifo_bytes} >= (CNT_W+1)'({fifo_samples, 1'b0}));

  assign store.fifo_wr      = wr;
  assign store.fifo_wr_data = wr ? fmt_byte : 8'h00;
  assign store.fifo_rd      = rd;
  assign store.fifo_flush   = flush;
  assign dbg_state          = state;

endmodule

// File: tb/tb_adxl362_fifo_ctrl.sv
// Directed bench for adxl362_fifo_ctrl: byte-queue scoreboard, per-cycle count model, literal pins.
// Covers the ADXL362_FIFO_TEMP_EN build as well as the default build.
module tb_adxl362_fifo_ctrl;
  import adxl362_pkg::*;

`ifdef ADXL362_FIFO_TEMP_EN
  localparam int T_SET = 8;
`else
  localparam int T_SET = 6;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid, fifo_temp, rd_req, ovr_clr;
  logic [11:0] sample_x, sample_y, sample_z, sample_t;
  logic [1:0]  fifo_mode;
  logic [8:0]  fifo_samples;
  logic [9:0]  fifo_bytes;
  logic        watermark, overrun, busy;
  fifo_state_e dbg_state;

  adxl362_fifo_ctrl_if store ();

  adxl362_fifo_ctrl #(.DEPTH_BYTES(512), .CNT_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_t     (sample_t),
    .fifo_mode    (fifo_mode),
    .fifo_temp    (fifo_temp),
    .fifo_samples (fifo_samples),
    .rd_req       (rd_req),
    .ovr_clr      (ovr_clr),
    .store        (store),
    .fifo_bytes   (fifo_bytes),
    .watermark    (watermark),
    .overrun      (overrun),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  int         model_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_dat_q[$];
  int         wr_cyc_q[$];
  int         rd_cyc_q[$];
  int         fl_cyc_q[$];
  logic [7:0] t1_exp [6] = '{8'hFF, 8'h07, 8'h00, 8'h78, 8'h01, 8'h80};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Entry = tag in [15:14], two copies of the sign bit, then the 12-bit value.
  function automatic logic [7:0] exp_byte(input int axis, input logic [11:0] d, input bit hi);
    logic [15:0] e;
    e = 16'(axis * 16384) + (d[11] ? 16'd12288 : 16'd0) + {4'h0, d};
    return hi ? e[15:8] : e[7:0];
  endfunction

  task automatic push_entry(input int axis, input logic [11:0] d);
    exp_q.push_back(exp_byte(axis, d, 1'b0));
    exp_q.push_back(exp_byte(axis, d, 1'b1));
  endtask

  // Per-cycle compare: count model is the running sum of strobes, flush empties it.
  always @(negedge clk) begin
    if (!reset) begin
      chk("fifo_bytes", fifo_bytes, model_cnt);
      chk("watermark", watermark,
          int'(fifo_samples != 0 && model_cnt >= 2 * int'(fifo_samples)));
      chk("single_op", int'(store.fifo_wr && store.fifo_rd), 0);
      if (store.fifo_wr) begin
        wr_cyc_q.push_back(cyc);
        wr_dat_q.push_back(store.fifo_wr_data);
        if (exp_q.size() == 0) chk("wr_unexpected", store.fifo_wr, 0);
        else chk("wr_data", store.fifo_wr_data, exp_q.pop_front());
        model_cnt++;
      end
      if (store.fifo_rd) begin
        rd_cyc_q.push_back(cyc);
        chk("rd_underflow", int'(model_cnt > 0), 1);
        model_cnt--;
      end
      if (store.fifo_flush) begin
        fl_cyc_q.push_back(cyc);
        model_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wr_dat_q.delete();
    wr_cyc_q.delete();
    rd_cyc_q.delete();
    fl_cyc_q.delete();
  endtask

  task automatic send(input logic [11:0] x, y, z, t, input int exp_n, output int n);
    sample_x = x; sample_y = y; sample_z = z; sample_t = t;
    sample_valid = 1'b1;
    n = cyc;
    if (exp_n >= 6) begin
      push_entry(0, x);
      push_entry(1, y);
      push_entry(2, z);
    end
    if (exp_n == 8) push_entry(3, t);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic send_rand(input int exp_n, output int n);
    send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
         12'($urandom_range(0, 4095)), 12'h000, exp_n, n);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      step();
      k++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    step();
  endtask

  task automatic pop(input int n);
    rd_req = 1'b1;
    step(n);
    rd_req = 1'b0;
  endtask

  task automatic clr_ovr();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
  endtask

  task automatic flush_to(input logic [1:0] m);
    fifo_mode = FIFO_DISABLED;
    exp_q.delete();
    step(2);
    fifo_mode = m;
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, n2;
    reset = 1'b1;
    sample_valid = 1'b0; fifo_temp = 1'b0; rd_req = 1'b0; ovr_clr = 1'b0;
    sample_x = '0; sample_y = '0; sample_z = '0; sample_t = '0;
    fifo_mode = FIFO_DISABLED; fifo_samples = '0;
    step(3);
    chk("rst_bytes", fifo_bytes, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_watermark", watermark, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", store.fifo_wr, 0);
    chk("rst_rd", store.fifo_rd, 0);
    chk("rst_flush", store.fifo_flush, 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));
    reset = 1'b0;
    step();

    // T1: stream mode, formatted bytes and minimum latency
    fifo_mode = FIFO_STREAM;
    step();
    clear_logs();
    send(12'h7FF, 12'h800, 12'h001, 12'h000, 6, n);
    wait_idle(20);
    chk("t1_wr_count", wr_dat_q.size(), 6);
    if (wr_dat_q.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t1_byte", wr_dat_q[i], t1_exp[i]);
      chk("t1_first_cyc", wr_cyc_q[0], n + 2);
      chk("t1_last_cyc", wr_cyc_q[5], n + 7);
    end
    chk("t1_bytes", fifo_bytes, 6);

    // T2: oldest-saved overflow discards the set
    flush_to(FIFO_OLDEST);
    chk("t2_flushed", fifo_bytes, 0);
    for (int i = 0; i < 85; i++) begin
      send_rand(6, n);
      wait_idle(20);
    end
    pop(2);
    step();
    chk("t2_prefill", fifo_bytes, 508);
    chk("t2_ovr_before", overrun, 0);
    clear_logs();
    send_rand(0, n);
    wait_idle(20);
    chk("t2_no_wr", wr_dat_q.size(), 0);
    chk("t2_overrun", overrun, 1);
    chk("t2_bytes", fifo_bytes, 508);
    clr_ovr();
    chk("t2_ovr_clr", overrun, 0);

    // T3: stream drops, first 2 then 4 bytes
    fifo_mode = FIFO_STREAM;
    step();
    clear_logs();
    send_rand(6, n);
    wait_idle(30);
    chk("t3a_drops", rd_cyc_q.size(), 2);
    chk("t3a_writes", wr_dat_q.size(), 6);
    chk("t3a_bytes", fifo_bytes, 512);
    chk("t3a_overrun", overrun, 1);
    pop(2);
    step();
    chk("t3b_start", fifo_bytes, 510);
    clr_ovr();
    chk("t3b_ovr_clr", overrun, 0);
    clear_logs();
    send_rand(6, n);
    wait_idle(30);
    chk("t3b_drops", rd_cyc_q.size(), 4);
    chk("t3b_writes", wr_dat_q.size(), 6);
    if (rd_cyc_q.size() == 4 && wr_cyc_q.size() == 6) begin
      chk("t3b_first_drop", rd_cyc_q[0], n + 2);
      chk("t3b_first_wr", wr_cyc_q[0], n + 6);
    end
    chk("t3b_bytes", fifo_bytes, 512);
    chk("t3b_overrun", overrun, 1);

    // T4: SPI pop preempts the writer at byte 2
    flush_to(FIFO_STREAM);
    chk("t4_ovr_kept", overrun, 1);
    clear_logs();
    send(12'h155, 12'hAAA, 12'h3C0, 12'h000, 6, n);
    step(3);
    pop(1);
    wait_idle(20);
    chk("t4_pops", rd_cyc_q.size(), 1);
    chk("t4_writes", wr_dat_q.size(), 6);
    if (rd_cyc_q.size() == 1 && wr_cyc_q.size() == 6) begin
      chk("t4_pop_cyc", rd_cyc_q[0], n + 4);
      chk("t4_byte2_cyc", wr_cyc_q[2], n + 5);
      chk("t4_last_cyc", wr_cyc_q[5], n + 8);
    end
    chk("t4_bytes", fifo_bytes, 5);

    // T5: watermark threshold at 2*fifo_samples bytes
    flush_to(FIFO_STREAM);
    fifo_samples = 9'd3;
    send_rand(6, n);
    wait_idle(20);
    chk("t5_bytes6", fifo_bytes, 6);
    chk("t5_wm_at6", watermark, 1);
    pop(1);
    step();
    chk("t5_wm_at5", watermark, 0);
    send_rand(6, n);
    wait_idle(20);
    chk("t5_bytes11", fifo_bytes, 11);
    chk("t5_wm_at11", watermark, 1);
    fifo_samples = 9'd0;
    step();
    chk("t5_wm_disabled", watermark, 0);
    fifo_samples = 9'd6;
    step();
    chk("t5_wm_below12", watermark, 0);
    fifo_samples = 9'd0;

    // T6: temperature entry, then flush mid-set
    flush_to(FIFO_STREAM);
    clear_logs();
    fifo_temp = 1'b1;
    send(12'h0F0, 12'hF0F, 12'h7FF, 12'h123, T_SET, n);
    fifo_temp = 1'b0;
    wait_idle(20);
    chk("t6_writes", wr_dat_q.size(), T_SET);
    chk("t6_bytes", fifo_bytes, T_SET);
`ifdef ADXL362_FIFO_TEMP_EN
    if (wr_dat_q.size() == 8) begin
      chk("t6_t_lo", wr_dat_q[6], 8'h23);
      chk("t6_t_hi", wr_dat_q[7], 8'hC1);
    end
`endif
    flush_to(FIFO_STREAM);
    clear_logs();
    send_rand(6, n);
    step(3);
    fifo_mode = FIFO_DISABLED;
    exp_q.delete();
    step();
    chk("t6_flush_busy", busy, 0);
    chk("t6_flush_bytes", fifo_bytes, 0);
    chk("t6_flush_count", fl_cyc_q.size(), 1);
    if (fl_cyc_q.size() == 1) chk("t6_flush_cyc", fl_cyc_q[0], n + 4);
    chk("t6_partial_wr", wr_dat_q.size(), 2);
    send_rand(0, n);
    chk("t6_disabled_busy", busy, 0);
    step(8);
    chk("t6_disabled_wr", wr_dat_q.size(), 2);

    // T7: sample arriving while busy is dropped
    fifo_mode = FIFO_STREAM;
    step();
    clr_ovr();
    chk("t7_ovr_clr", overrun, 0);
    clear_logs();
    send_rand(6, n);
    step();
    send_rand(0, n2);
    wait_idle(20);
    chk("t7_writes", wr_dat_q.size(), 6);
    chk("t7_overrun", overrun, 1);
    chk("t7_bytes", fifo_bytes, 6);

    step(2);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
